// File: rtl/tt_um_rps_match.sv
// Stone-paper-scissors match controller: lock strobes, judging, scores, match end.
// Define RPS_INVALID_FORFEIT_EN to make a single invalid move forfeit the round.
module tt_um_rps_match #(
  parameter int ROUNDS_TO_WIN = 3,
  parameter int MAX_ROUNDS    = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [1:0] COLLECT = 2'b00;
  localparam logic [1:0] JUDGE   = 2'b01;
  localparam logic [1:0] SHOW    = 2'b10;
  localparam logic [1:0] OVER    = 2'b11;

  localparam logic [1:0] STONE = 2'b00;
  localparam logic [1:0] PAPER = 2'b01;
  localparam logic [1:0] SCIS  = 2'b10;
  localparam logic [1:0] INV   = 2'b11;

  localparam logic [1:0] R_TIE  = 2'b00;
  localparam logic [1:0] R_P1   = 2'b01;
  localparam logic [1:0] R_P2   = 2'b10;
  localparam logic [1:0] R_VOID = 2'b11;

  localparam logic [3:0] WIN_T = ROUNDS_TO_WIN[3:0];
  localparam logic [3:0] MAX_T = MAX_ROUNDS[3:0];

`ifdef RPS_INVALID_FORFEIT_EN
  localparam logic [1:0] P1_BAD = R_P2;
  localparam logic [1:0] P2_BAD = R_P1;
`else
  localparam logic [1:0] P1_BAD = R_VOID;
  localparam logic [1:0] P2_BAD = R_VOID;
`endif

  logic [1:0] state;
  logic [1:0] m1;
  logic [1:0] m2;
  logic       lk1;
  logic       lk2;
  logic [1:0] result;
  logic [1:0] match;
  logic [3:0] s1;
  logic [3:0] s2;
  logic [3:0] rounds;
  logic       l1_q;
  logic       l2_q;
  logic       nx_q;

  logic       l1_rise;
  logic       l2_rise;
  logic       nx_rise;
  logic       clr;
  logic       wipe;
  logic       beats1;
  logic [1:0] verdict;
  logic [3:0] s1_n;
  logic [3:0] s2_n;
  logic [3:0] rounds_n;
  logic       unused_ok;

  assign l1_rise = ui_in[2] & ~l1_q;
  assign l2_rise = ui_in[5] & ~l2_q;
  assign nx_rise = ui_in[6] & ~nx_q;
  assign clr     = ui_in[7];

  // OVER exit and clear share the same full wipe
  assign wipe = clr | ((state == OVER) & nx_rise);

  assign beats1 = ((m1 == PAPER) & (m2 == STONE)) |
                  ((m1 == SCIS)  & (m2 == PAPER)) |
                  ((m1 == STONE) & (m2 == SCIS));

  always_comb begin
    verdict = R_P2;
    unique case (1'b1)
      (m1 == INV) & (m2 == INV): verdict = R_VOID;
      (m1 == INV) & (m2 != INV): verdict = P1_BAD;
      (m2 == INV) & (m1 != INV): verdict = P2_BAD;
      (m1 == m2) & (m1 != INV):  verdict = R_TIE;
      beats1:                    verdict = R_P1;
      default:                   verdict = R_P2;
    endcase
  end

  assign s1_n     = s1 + {3'b000, verdict == R_P1};
  assign s2_n     = s2 + {3'b000, verdict == R_P2};
  assign rounds_n = rounds + {3'b000, verdict != R_VOID};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= COLLECT;
      m1     <= STONE;
      m2     <= STONE;
      lk1    <= 1'b0;
      lk2    <= 1'b0;
      result <= R_TIE;
      match  <= 2'b00;
      s1     <= 4'd0;
      s2     <= 4'd0;
      rounds <= 4'd0;
      l1_q   <= 1'b0;
      l2_q   <= 1'b0;
      nx_q   <= 1'b0;
    end else if (ena) begin
      l1_q <= ui_in[2];
      l2_q <= ui_in[5];
      nx_q <= ui_in[6];
      if (wipe) begin
        state  <= COLLECT;
        lk1    <= 1'b0;
        lk2    <= 1'b0;
        result <= R_TIE;
        match  <= 2'b00;
        s1     <= 4'd0;
        s2     <= 4'd0;
        rounds <= 4'd0;
      end else begin
        unique case (state)
          COLLECT: begin
            if (l1_rise && !lk1) begin
              m1  <= ui_in[1:0];
              lk1 <= 1'b1;
            end
            if (l2_rise && !lk2) begin
              m2  <= ui_in[4:3];
              lk2 <= 1'b1;
            end
            if ((lk1 | l1_rise) & (lk2 | l2_rise))
              state <= JUDGE;
          end
          JUDGE: begin
            result <= verdict;
            s1     <= s1_n;
            s2     <= s2_n;
            rounds <= rounds_n;
            // a win reached this round outranks the round-limit draw
            if (s1_n == WIN_T) begin
              match <= R_P1;
              state <= OVER;
            end else if (s2_n == WIN_T) begin
              match <= R_P2;
              state <= OVER;
            end else if (rounds_n == MAX_T) begin
              match <= 2'b11;
              state <= OVER;
            end else begin
              state <= SHOW;
            end
          end
          SHOW: begin
            if (nx_rise) begin
              lk1   <= 1'b0;
              lk2   <= 1'b0;
              state <= COLLECT;
            end
          end
          OVER: begin
            state <= OVER;
          end
          default: state <= COLLECT;
        endcase
      end
    end
  end

  assign uo_out    = {state, match, lk2, lk1, result};
  assign uio_out   = {s2, s1};
  assign uio_oe    = 8'hFF;
  assign unused_ok = ^uio_in;

endmodule

// File: tb/tb_tt_um_rps_match.sv
// Randomised bench for tt_um_rps_match against a rule-level match model.
// A second instance with MAX_ROUNDS=3 covers the short-match draw.
module tb_tt_um_rps_match;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic [7:0] uo3;
  logic [7:0] uio3;
  logic [7:0] oe3;

  int errors;
  int checks;

  localparam int RTW  = 3;
  localparam int MAXR = 9;
`ifdef RPS_INVALID_FORFEIT_EN
  localparam bit FORFEIT = 1'b1;
`else
  localparam bit FORFEIT = 1'b0;
`endif

  int         m_s1;
  int         m_s2;
  int         m_rounds;
  logic [1:0] m_result;
  logic [1:0] m_match;
  logic [1:0] m_state;
  logic       m_l1;
  logic       m_l2;

  tt_um_rps_match dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in),
    .uo_out(uo_out), .uio_in(uio_in), .uio_out(uio_out),
    .uio_oe(uio_oe)
  );

  tt_um_rps_match #(.ROUNDS_TO_WIN(3), .MAX_ROUNDS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in),
    .uo_out(uo3), .uio_in(uio_in), .uio_out(uio3),
    .uio_oe(oe3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // 0 tie, 1 P1, 2 P2, 3 void
  function automatic logic [1:0] judge(input logic [1:0] a,
                                       input logic [1:0] b);
    int d;
    if (a == 2'd3 && b == 2'd3) return 2'd3;
    if (a == 2'd3) return FORFEIT ? 2'd2 : 2'd3;
    if (b == 2'd3) return FORFEIT ? 2'd1 : 2'd3;
    d = (int'(a) + 3 - int'(b)) % 3;
    if (d == 0) return 2'd0;
    if (d == 1) return 2'd1;
    return 2'd2;
  endfunction

  task automatic model_clear;
    m_s1 = 0; m_s2 = 0; m_rounds = 0;
    m_result = 2'd0; m_match = 2'd0; m_state = 2'd0;
    m_l1 = 1'b0; m_l2 = 1'b0;
  endtask

  task automatic model_round(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] v;
    v = judge(a, b);
    m_result = v;
    m_l1 = 1'b1;
    m_l2 = 1'b1;
    if (v == 2'd1) m_s1++;
    if (v == 2'd2) m_s2++;
    if (v != 2'd3) m_rounds++;
    if (m_s1 == RTW) begin
      m_match = 2'd1; m_state = 2'd3;
    end else if (m_s2 == RTW) begin
      m_match = 2'd2; m_state = 2'd3;
    end else if (m_rounds == MAXR) begin
      m_match = 2'd3; m_state = 2'd3;
    end else begin
      m_state = 2'd2;
    end
  endtask

  function automatic logic [7:0] exp_uo();
    return {m_state, m_match, m_l2, m_l1, m_result};
  endfunction

  function automatic logic [7:0] exp_uio();
    logic [3:0] a;
    logic [3:0] b;
    a = m_s1[3:0];
    b = m_s2[3:0];
    return {b, a};
  endfunction

  task automatic play(input logic [1:0] a, input logic [1:0] b);
    ui_in[1:0] = a;
    ui_in[4:3] = b;
    ui_in[2] = 1'b1;
    ui_in[5] = 1'b1;
    tick;
    ui_in[2] = 1'b0;
    ui_in[5] = 1'b0;
    tick;
    model_round(a, b);
  endtask

  task automatic pulse_next;
    ui_in[6] = 1'b1;
    tick;
    ui_in[6] = 1'b0;
    tick;
    if (m_state == 2'd3) model_clear;
    else begin
      m_l1 = 1'b0; m_l2 = 1'b0; m_state = 2'd0;
    end
  endtask

  task automatic pulse_clear;
    ui_in[7] = 1'b1;
    tick;
    ui_in[7] = 1'b0;
    tick;
    model_clear;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    ena = 1'b1;
    ui_in = 8'h00;
    uio_in = 8'h00;
    tick;
    tick;
    checks++;
    if (uo_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_uo got=%h exp=00", uo_out);
    end
    checks++;
    if (uio_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_uio got=%h exp=00", uio_out);
    end
    checks++;
    if (uio_oe !== 8'hFF) begin
      errors++;
      $display("FAIL uio_oe got=%h exp=ff", uio_oe);
    end
    rst_n = 1'b1;
    tick;
    model_clear;
  endtask

  task automatic test_same_cycle;
    ui_in[1:0] = 2'd1;
    ui_in[4:3] = 2'd0;
    ui_in[2] = 1'b1;
    ui_in[5] = 1'b1;
    tick;
    checks++;
    if (uo_out !== 8'h4C) begin
      errors++;
      $display("FAIL judge_state got=%h exp=4c", uo_out);
    end
    ui_in[2] = 1'b0;
    ui_in[5] = 1'b0;
    tick;
    model_round(2'd1, 2'd0);
    checks++;
    if (uo_out !== exp_uo()) begin
      errors++;
      $display("FAIL same_cycle_uo got=%h exp=%h", uo_out, exp_uo());
    end
    checks++;
    if (uio_out !== 8'h01) begin
      errors++;
      $display("FAIL same_cycle_uio got=%h exp=01", uio_out);
    end
    pulse_next;
    checks++;
    if (uo_out !== exp_uo()) begin
      errors++;
      $display("FAIL show_next got=%h exp=%h", uo_out, exp_uo());
    end
  endtask

  task automatic test_relock;
    ui_in[1:0] = 2'd0;
    ui_in[2] = 1'b1;
    tick;
    checks++;
    if (uo_out[3:2] !== 2'b01) begin
      errors++;
      $display("FAIL p1_lock got=%b exp=01", uo_out[3:2]);
    end
    ui_in[2] = 1'b0;
    ui_in[1:0] = 2'd2;
    tick;
    ui_in[2] = 1'b1;
    tick;
    ui_in[2] = 1'b0;
    ui_in[4:3] = 2'd1;
    ui_in[5] = 1'b1;
    tick;
    ui_in[5] = 1'b0;
    tick;
    model_round(2'd0, 2'd1);
    checks++;
    if (uo_out !== exp_uo() || uo_out[1:0] !== 2'b10) begin
      errors++;
      $display("FAIL relock_uo got=%h exp=%h", uo_out, exp_uo());
    end
    checks++;
    if (uio_out !== exp_uio()) begin
      errors++;
      $display("FAIL relock_uio got=%h exp=%h", uio_out, exp_uio());
    end
    pulse_next;
  endtask

  task automatic test_match_win;
    logic [1:0] a [3];
    logic [1:0] b [3];
    a[0] = 2'd1; b[0] = 2'd0;
    a[1] = 2'd0; b[1] = 2'd2;
    a[2] = 2'd2; b[2] = 2'd1;
    pulse_clear;
    for (int i = 0; i < 3; i++) begin
      play(a[i], b[i]);
      checks++;
      if (uo_out !== exp_uo() || uio_out !== exp_uio()) begin
        errors++;
        $display("FAIL win_round%0d got=%h/%h exp=%h/%h", i,
                 uo_out, uio_out, exp_uo(), exp_uio());
      end
      if (i < 2) pulse_next;
    end
    checks++;
    if (uo_out[7:4] !== 4'b1101 || uio_out !== 8'h03) begin
      errors++;
      $display("FAIL win_over got=%h/%h exp=dX/03", uo_out, uio_out);
    end
    pulse_next;
    checks++;
    if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
      errors++;
      $display("FAIL over_next got=%h/%h exp=00/00", uo_out, uio_out);
    end
  endtask

  task automatic test_draw;
    logic [1:0] mv;
    pulse_clear;
    for (int i = 0; i < MAXR; i++) begin
      mv = 2'($urandom_range(0, 2));
      play(mv, mv);
      if (i == 2) begin
        checks++;
        if (uo3 !== 8'hFC || uio3 !== 8'h00) begin
          errors++;
          $display("FAIL short_draw got=%h/%h exp=fc/00", uo3, uio3);
        end
      end
      if (i == 2 || i == MAXR - 1) begin
        checks++;
        if (uo_out !== exp_uo() || uio_out !== exp_uio()) begin
          errors++;
          $display("FAIL tie_round%0d got=%h/%h exp=%h/%h", i,
                   uo_out, uio_out, exp_uo(), exp_uio());
        end
      end
      if (i < MAXR - 1) pulse_next;
    end
    checks++;
    if (uo_out[7:4] !== 4'hF) begin
      errors++;
      $display("FAIL long_draw got=%h exp=fX", uo_out);
    end
    pulse_next;
  endtask

  task automatic test_invalid;
    logic [1:0] a [3];
    logic [1:0] b [3];
    a[0] = 2'd3; b[0] = 2'd0;
    a[1] = 2'd3; b[1] = 2'd3;
    a[2] = 2'd1; b[2] = 2'd3;
    pulse_clear;
    for (int i = 0; i < 3; i++) begin
      play(a[i], b[i]);
      checks++;
      if (uo_out !== exp_uo() || uio_out !== exp_uio()) begin
        errors++;
        $display("FAIL invalid%0d got=%h/%h exp=%h/%h", i,
                 uo_out, uio_out, exp_uo(), exp_uio());
      end
      pulse_next;
    end
  endtask

  task automatic test_clear;
    pulse_clear;
    ui_in[1:0] = 2'd1;
    ui_in[4:3] = 2'd0;
    ui_in[2] = 1'b1;
    ui_in[5] = 1'b1;
    tick;
    ui_in[2] = 1'b0;
    ui_in[5] = 1'b0;
    ui_in[7] = 1'b1;
    tick;
    checks++;
    if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
      errors++;
      $display("FAIL clear_judge got=%h/%h exp=00/00", uo_out, uio_out);
    end
    ui_in[2] = 1'b1;
    tick;
    checks++;
    if (uo_out !== 8'h00) begin
      errors++;
      $display("FAIL clear_held got=%h exp=00", uo_out);
    end
    ui_in[2] = 1'b0;
    ui_in[7] = 1'b0;
    tick;
    model_clear;
    play(2'd2, 2'd1);
    ui_in[7] = 1'b1;
    tick;
    checks++;
    if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
      errors++;
      $display("FAIL clear_show got=%h/%h exp=00/00", uo_out, uio_out);
    end
    ui_in[7] = 1'b0;
    tick;
    model_clear;
    ui_in[2] = 1'b1;
    tick;
    ui_in[2] = 1'b0;
    tick;
    rst_n = 1'b0;
    ui_in[2] = 1'b1;
    tick;
    checks++;
    if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid got=%h/%h exp=00/00", uo_out, uio_out);
    end
    rst_n = 1'b1;
    tick;
    checks++;
    if (uo_out !== 8'h04) begin
      errors++;
      $display("FAIL held_strobe got=%h exp=04", uo_out);
    end
    ui_in[2] = 1'b0;
    tick;
    pulse_clear;
  endtask

  task automatic test_ena;
    ena = 1'b0;
    ui_in[2] = 1'b1;
    tick;
    ui_in[2] = 1'b0;
    tick;
    ena = 1'b1;
    tick;
    checks++;
    if (uo_out !== exp_uo()) begin
      errors++;
      $display("FAIL ena_lock got=%h exp=%h", uo_out, exp_uo());
    end
    play(2'd0, 2'd2);
    ena = 1'b0;
    ui_in[6] = 1'b1;
    tick;
    ui_in[6] = 1'b0;
    tick;
    ena = 1'b1;
    tick;
    checks++;
    if (uo_out !== exp_uo() || uio_out !== exp_uio()) begin
      errors++;
      $display("FAIL ena_next got=%h/%h exp=%h/%h",
               uo_out, uio_out, exp_uo(), exp_uio());
    end
    pulse_next;
  endtask

  task automatic test_random;
    logic [1:0] a;
    logic [1:0] b;
    pulse_clear;
    for (int n = 0; n < 60; n++) begin
      a = 2'($urandom_range(0, 3));
      b = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        ui_in[1:0] = a;
        ui_in[2] = 1'b1;
        tick;
        ui_in[2] = 1'b0;
        ui_in[1:0] = 2'($urandom_range(0, 3));
        tick;
        ui_in[2] = 1'b1;
        tick;
        ui_in[2] = 1'b0;
        m_l1 = 1'b1;
        checks++;
        if (uo_out !== exp_uo()) begin
          errors++;
          $display("FAIL rnd_half%0d got=%h exp=%h", n, uo_out, exp_uo());
        end
        ui_in[4:3] = b;
        ui_in[5] = 1'b1;
        tick;
        ui_in[5] = 1'b0;
        tick;
        model_round(a, b);
      end else begin
        play(a, b);
      end
      checks++;
      if (uo_out !== exp_uo() || uio_out !== exp_uio()) begin
        errors++;
        $display("FAIL rnd_round%0d a=%0d b=%0d got=%h/%h exp=%h/%h",
                 n, a, b, uo_out, uio_out, exp_uo(), exp_uio());
      end
      ui_in[5] = 1'b1;
      tick;
      ui_in[5] = 1'b0;
      tick;
      pulse_next;
      checks++;
      if (uo_out !== exp_uo() || uio_out !== exp_uio()) begin
        errors++;
        $display("FAIL rnd_next%0d got=%h/%h exp=%h/%h",
                 n, uo_out, uio_out, exp_uo(), exp_uio());
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset;
    test_same_cycle;
    test_relock;
    test_match_win;
    test_draw;
    test_invalid;
    test_clear;
    test_ena;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
